// File: rtl/rd_ctrl.sv
// AXI4 read-channel master: issues single AR bursts, tracks outstanding bursts, registers R beats to the user.
// Optional macro RD_LEN_CHECK_EN adds per-burst beat-count checking against the issued ARLEN.
module rd_ctrl #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic [CTRL_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [3:0]                   rd_id,
  input  logic [3:0]                   rd_len,
  output logic                         rd_cmd_ready,
  output logic                         rd_data_valid,
  output logic [MEM_DQ_WIDTH*8-1:0]    rd_data,
  output logic [3:0]                   rd_data_id,
  output logic                         rd_data_last,
  output logic                         rd_busy,
  output logic                         rd_err,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arid,
  output logic [3:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic [3:0]                   axi_rid,
  input  logic [1:0]                   axi_rresp,
  input  logic                         axi_rlast,
  input  logic                         axi_rvalid,
  output logic                         axi_rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;

  ar_state_t     state_q, state_d;
  logic [CW-1:0] out_cnt;
  logic          ar_hs, r_hs, r_last_hs, cmd_accept, err_set, len_err;

  assign ar_hs        = axi_arvalid & axi_arready;
  assign r_hs         = axi_rvalid & axi_rready;
  assign r_last_hs    = r_hs & axi_rlast;
  assign rd_cmd_ready = !rst && (state_q == AR_IDLE) && (out_cnt < MAX_CNT);
  assign cmd_accept   = rd_en & rd_cmd_ready;
  assign rd_busy      = axi_arvalid || (out_cnt != '0);
  assign axi_arsize   = 3'b110;
  assign axi_arburst  = 2'b01;

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_IDLE: if (cmd_accept) state_d = AR_REQ;
      AR_REQ:  if (ar_hs)      state_d = AR_IDLE;
      default: state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= AR_IDLE;
      axi_araddr  <= '0;
      axi_arid    <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_accept) begin
        axi_araddr  <= rd_addr;
        axi_arid    <= rd_id;
        axi_arlen   <= rd_len;
        axi_arvalid <= 1'b1;
      end else if (ar_hs) begin
        axi_arvalid <= 1'b0;
      end
    end
  end

  // Simultaneous issue and completion cancel; completion at zero holds and is flagged below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (ar_hs && !r_last_hs) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (r_last_hs && !ar_hs && (out_cnt != '0)) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

`ifdef RD_LEN_CHECK_EN
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [3:0]    len_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    beat_cnt, head_len;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_len = len_fifo[rd_ptr];
  assign len_err  = r_hs && (out_cnt != '0) &&
                    (axi_rlast ? (beat_cnt != head_len) : (beat_cnt == head_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) len_fifo[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (ar_hs) begin
        len_fifo[wr_ptr] <= axi_arlen;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (r_last_hs && (out_cnt != '0)) rd_ptr <= next_ptr(rd_ptr);
      if (r_hs) beat_cnt <= axi_rlast ? 4'd0 : beat_cnt + 4'd1;
    end
  end
`else
  assign len_err = 1'b0;
`endif

  assign err_set = (r_hs && ((axi_rresp != 2'b00) || (axi_rlast && (out_cnt == '0)))) || len_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_rready    <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      rd_data_id    <= '0;
      rd_data_last  <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      axi_rready    <= 1'b1;
      rd_data_valid <= r_hs;
      if (r_hs) begin
        rd_data      <= axi_rdata;
        rd_data_id   <= axi_rid;
        rd_data_last <= axi_rlast;
      end
      if (err_set) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_ctrl.sv
// Directed bench for rd_ctrl: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_rd_ctrl;
  localparam int AW = 28;
  localparam int DW = 128;
`ifdef RD_LEN_CHECK_EN
  localparam logic LE = 1'b1;
`else
  localparam logic LE = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [3:0]    rd_id = '0, rd_len = '0;
  logic          rd_cmd_ready, rd_data_valid, rd_data_last, rd_busy, rd_err;
  logic [DW-1:0] rd_data;
  logic [3:0]    rd_data_id;
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_arid, axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid, axi_rready;
  logic          axi_arready = 1'b0;
  logic [DW-1:0] axi_rdata = '0;
  logic [3:0]    axi_rid = '0;
  logic [1:0]    axi_rresp = '0;
  logic          axi_rlast = 1'b0, axi_rvalid = 1'b0;

  int checks = 0, errors = 0, ar_cnt = 0;

  rd_ctrl #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(16), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_id(rd_id), .rd_len(rd_len),
    .rd_cmd_ready(rd_cmd_ready), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .rd_data_id(rd_data_id), .rd_data_last(rd_data_last), .rd_busy(rd_busy), .rd_err(rd_err),
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (axi_arvalid && axi_arready) ar_cnt++;

  typedef struct {
    logic rst, en; logic [AW-1:0] addr; logic [3:0] id, len;
    logic ar, rv; logic [3:0] rid; logic [31:0] d; logic [1:0] rr; logic rl;
    logic [4:0] e;    // {arvalid, cmd_ready, data_valid, busy, err}
    logic erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, en, input logic [AW-1:0] a, input logic [3:0] id, l,
                              input logic ar, rv, input logic [3:0] rid, input logic [31:0] d,
                              input logic [1:0] rr, input logic rl, input logic [4:0] e,
                              input logic erdy);
    vec_t v;
    v.rst = r; v.en = en; v.addr = a; v.id = id; v.len = l; v.ar = ar; v.rv = rv;
    v.rid = rid; v.d = d; v.rr = rr; v.rl = rl; v.e = e; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [3:0] rid, input logic [31:0] d, input logic [1:0] rr, input logic rl);
    axi_rvalid = 1'b1; axi_rid = rid; axi_rdata = {4{d}}; axi_rresp = rr; axi_rlast = rl;
  endtask

  task automatic idle_r();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
  endtask

  // Command with arready held high: accepted on the first edge, handshaken on the second.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [3:0] id, input logic [3:0] l);
    axi_arready = 1'b1; rd_en = 1'b1; rd_addr = a; rd_id = id; rd_len = l;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    //            rst en addr    id len ar rv rid d      rr rl  e(av,rdy,dv,busy,err) rready
    vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, 0,     0, 0, 5'b01000, 1));
    vecs.push_back(mk(0, 1, 'h100,  2, 3, 1, 0, 0, 0,     0, 0, 5'b10010, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b01010, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 2, 'hD0,  0, 0, 5'b01110, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 2, 'hD1,  0, 0, 5'b01110, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 2, 'hD2,  0, 0, 5'b01110, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 2, 'hD3,  0, 1, 5'b01100, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b01000, 1));
    vecs.push_back(mk(0, 1, 'h200,  5, 1, 1, 0, 0, 0,     0, 0, 5'b10010, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b01010, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 5, 'hE0,  2, 0, 5'b01111, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 5, 'hE1,  0, 1, 5'b01101, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b01001, 1));
    vecs.push_back(mk(1, 0, 0,      0, 0, 1, 1, 0, 'h77,  0, 1, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 0, 'h78,  0, 1, 5'b01000, 1));
    vecs.push_back(mk(0, 1, 'h300,  7, 3, 1, 0, 0, 0,     0, 0, 5'b10010, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b01010, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 7, 'hF0,  0, 0, 5'b01110, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 7, 'hF1,  0, 1, {4'b0110, LE}, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, {4'b0100, LE}, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 0, 'h11,  0, 1, 5'b01101, 1));
    vecs.push_back(mk(1, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 0, 0, 0,     0, 0, 5'b01000, 1));

    @(negedge clk);
    chk("reset arsize", axi_arsize, 3'b110);
    chk("reset arburst", axi_arburst, 2'b01);
    foreach (vecs[k]) begin
      rst = vecs[k].rst; rd_en = vecs[k].en; rd_addr = vecs[k].addr; rd_id = vecs[k].id;
      rd_len = vecs[k].len; axi_arready = vecs[k].ar; axi_rvalid = vecs[k].rv;
      axi_rid = vecs[k].rid; axi_rdata = {4{vecs[k].d}}; axi_rresp = vecs[k].rr;
      axi_rlast = vecs[k].rl;
      @(negedge clk);
      chk($sformatf("row%0d arvalid", k), axi_arvalid, vecs[k].e[4]);
      chk($sformatf("row%0d cmd_ready", k), rd_cmd_ready, vecs[k].e[3]);
      chk($sformatf("row%0d data_valid", k), rd_data_valid, vecs[k].e[2]);
      chk($sformatf("row%0d busy", k), rd_busy, vecs[k].e[1]);
      chk($sformatf("row%0d err", k), rd_err, vecs[k].e[0]);
      chk($sformatf("row%0d rready", k), axi_rready, vecs[k].erdy);
      if (vecs[k].e[2]) begin
        chk($sformatf("row%0d data", k), rd_data, {4{vecs[k].d}});
        chk($sformatf("row%0d data_id", k), rd_data_id, vecs[k].rid);
        chk($sformatf("row%0d data_last", k), rd_data_last, vecs[k].rl);
      end
      if (vecs[k].rst) begin
        chk($sformatf("row%0d rst data", k), rd_data, '0);
        chk($sformatf("row%0d rst araddr", k), axi_araddr, '0);
      end
    end
    idle_r();

    // AR backpressure: payload held, cmd_ready low, a mid-window rd_en is dropped.
    base = ar_cnt;
    axi_arready = 1'b0; rd_en = 1'b1; rd_addr = 'hABCDEF0; rd_id = 4'd9; rd_len = 4'd0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d arvalid", i), axi_arvalid, 1'b1);
      chk($sformatf("bp%0d araddr", i), axi_araddr, 'hABCDEF0);
      chk($sformatf("bp%0d arid", i), axi_arid, 4'd9);
      chk($sformatf("bp%0d arlen", i), axi_arlen, 4'd0);
      chk($sformatf("bp%0d cmd_ready", i), rd_cmd_ready, 1'b0);
      rd_en = (i == 2);
      if (i == 2) begin rd_addr = 'h555; rd_id = 4'd3; rd_len = 4'd5; end
      axi_arready = (i == 5);
      @(negedge clk);
    end
    rd_en = 1'b0;
    chk("bp release arvalid", axi_arvalid, 1'b0);
    chk("bp release busy", rd_busy, 1'b1);
    @(negedge clk);
    chk("bp dropped arvalid", axi_arvalid, 1'b0);
    chk("bp ar count", ar_cnt - base, 1);
    chk("bp araddr kept", axi_araddr, 'hABCDEF0);
    beat(4'd9, 32'h99, 2'b00, 1'b1);
    @(negedge clk);
    idle_r();
    chk("bp beat valid", rd_data_valid, 1'b1);
    chk("bp drained busy", rd_busy, 1'b0);
    chk("bp err", rd_err, 1'b0);

    // Outstanding limit, with AR handshake and rlast coinciding.
    send_cmd('h1000, 4'd1, 4'd0);
    send_cmd('h1100, 4'd2, 4'd0);
    send_cmd('h1200, 4'd3, 4'd0);
    chk("ol three ready", rd_cmd_ready, 1'b1);
    axi_arready = 1'b0; rd_en = 1'b1; rd_addr = 'h1300; rd_id = 4'd4; rd_len = 4'd0;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    chk("ol pending arvalid", axi_arvalid, 1'b1);
    axi_arready = 1'b1;
    beat(4'd1, 32'h101, 2'b00, 1'b1);
    @(negedge clk);
    idle_r();
    chk("ol coincide arvalid", axi_arvalid, 1'b0);
    chk("ol coincide dvalid", rd_data_valid, 1'b1);
    chk("ol coincide ready", rd_cmd_ready, 1'b1);
    send_cmd('h1400, 4'd5, 4'd0);
    chk("ol full ready", rd_cmd_ready, 1'b0);
    base = ar_cnt;
    rd_en = 1'b1; rd_addr = 'h1500;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    chk("ol full dropped", axi_arvalid, 1'b0);
    chk("ol full no ar", ar_cnt - base, 0);
    for (int i = 0; i < 4; i++) begin
      beat(4'(i + 2), 32'h200 + 32'(i), 2'b00, 1'b1);
      @(negedge clk);
      chk($sformatf("ol drain%0d busy", i), rd_busy, (i != 3));
    end
    idle_r();
    chk("ol drained ready", rd_cmd_ready, 1'b1);
    chk("ol err", rd_err, 1'b0);

    // Asynchronous reset mid-burst.
    send_cmd('h2000, 4'd4, 4'd3);
    beat(4'd4, 32'hAA, 2'b10, 1'b0);
    @(negedge clk);
    idle_r();
    chk("mr beat valid", rd_data_valid, 1'b1);
    chk("mr err set", rd_err, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mr async dvalid", rd_data_valid, 1'b0);
    chk("mr async data", rd_data, '0);
    chk("mr async err", rd_err, 1'b0);
    chk("mr async busy", rd_busy, 1'b0);
    chk("mr async rready", axi_rready, 1'b0);
    chk("mr async ready", rd_cmd_ready, 1'b0);
    chk("mr async araddr", axi_araddr, '0);
    @(negedge clk);
    rst = 1'b0;
    beat(4'd4, 32'hAB, 2'b00, 1'b1);
    #1;
    chk("mr release rready", axi_rready, 1'b0);
    @(negedge clk);
    chk("mr first edge rready", axi_rready, 1'b1);
    chk("mr first edge dvalid", rd_data_valid, 1'b0);
    @(negedge clk);
    idle_r();
    chk("mr stale beat valid", rd_data_valid, 1'b1);
    chk("mr stale rlast err", rd_err, 1'b1);
    chk("mr stale busy", rd_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
